serial_output: RTL and testbench

- UART transmitter that sits directly downstream of the user design's rs232_tx stream output.
- Accepts 32-bit words over the stb/ack handshake and buffers them in a small FIFO.
- Serialises bits [7:0] of each word onto the board TX pin as 8N1, LSB first.
- Drives the rs232_tx / rs232_tx_stb / rs232_tx_ack trio at top level.

---
 rtl/serial_output_pkg.sv | 21 ++
 rtl/serial_output_fifo.sv | 57 +++++
 rtl/serial_output.sv | 161 ++++++++++++++++
 tb/tb_serial_output.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_output_pkg.sv
// Shared types and helpers for the serial_output UART transmitter.
package serial_output_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Clock cycles per bit, integer-truncated.
  function automatic int unsigned calc_div(input int unsigned clock_frequency,
                                           input int unsigned baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/serial_output_fifo.sv
// DEPTH x WIDTH synchronous FIFO with show-ahead read data and occupancy count.
module serial_output_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("serial_output_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign dout_c  = mem[rd_ptr];
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/serial_output.sv
// UART transmitter: buffers stb/ack words and sends bits [7:0] as 8N1, LSB first.
// Define SERIAL_OUTPUT_PARITY_EN to insert an even-parity bit (8E1).
module serial_output
  import serial_output_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned DEPTH           = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_stb,
  output logic              in_ack,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned DIV    = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

  if (DIV < 2) begin : g_div_chk
    $error("serial_output: CLOCK_FREQUENCY/BAUD_RATE must be >= 2");
  end

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_d;
  logic                 busy_d;
  logic                 bit_end;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCNT_W-1:0]    fifo_count;
  logic                 unused_upper;

  assign unused_upper = ^in_data[WORD_W-1:DATA_BITS];

  // No full-bypass: a pop on the same edge never opens the handshake.
  assign in_ack    = rst && !fifo_full;
  assign fifo_push = in_stb && in_ack;
  assign bit_end   = (cnt_q == CNT_W'(DIV - 1));

  serial_output_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .din     (in_data[DATA_BITS-1:0]),
    .pop     (fifo_pop),
    .dout_c  (fifo_dout),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
      busy    <= busy_d;
    end
  end

  // Next-state logic; the baud counter restarts on every state entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx;
    fifo_pop = 1'b0;
    busy_d   = (state_q != IDLE) || (fifo_count != '0);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_OUTPUT_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
            tx_d  = shift_q[bit_d];
          end
        end
      end
`ifdef SERIAL_OUTPUT_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_output.sv
// Directed bench for serial_output at DIV=8, DEPTH=4 (honours SERIAL_OUTPUT_PARITY_EN).
module tb_serial_output;

  localparam int DIV = 8;
`ifdef SERIAL_OUTPUT_PARITY_EN
  localparam int FL  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = 10;
  localparam bit PAR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_stb;
  logic        in_ack;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  exp_byte;
    logic        exp_par;
  } vec_t;

  serial_output #(
    .CLOCK_FREQUENCY (8),
    .BAUD_RATE       (1),
    .DEPTH           (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_stb  (in_stb),
    .in_ack  (in_ack),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; word is transferred on the next posedge, returns at the following negedge.
  task automatic push_word(input logic [31:0] w);
    in_data = w;
    in_stb  = 1'b1;
    chk("push_ack", 32'(in_ack), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_stb  = 1'b0;
    in_data = 32'hDEAD_BEEF;
  endtask

  // Called at the negedge just before the frame's first (START) edge.
  task automatic check_frame(input logic [7:0] b, input logic p, input string name);
    for (int k = 0; k < FL * DIV; k++) begin
      logic e;
      int   bi;
      bi = k / DIV;
      @(negedge clk);
      if (bi == 0)                 e = 1'b0;
      else if (bi <= 8)            e = b[bi-1];
      else if (PAR && (bi == 9))   e = p;
      else                         e = 1'b1;
      chk({name, "_tx"}, 32'(tx), 32'(e));
      chk({name, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  // busy stays high for the edge that leaves STOP, then drops.
  task automatic check_tail(input string name);
    @(negedge clk);
    chk({name, "_tail_tx"}, 32'(tx), 32'd1);
    chk({name, "_tail_busy1"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({name, "_tail_busy0"}, 32'(busy), 32'd0);
    chk({name, "_tail_ack"}, 32'(in_ack), 32'd1);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t b2b[6];
    vec_t ord[4];

    vecs[0] = '{32'hFFFF_FF55, 8'h55, 1'b0};
    vecs[1] = '{32'h0000_0041, 8'h41, 1'b0};
    vecs[2] = '{32'hABCD_EF00, 8'h00, 1'b0};
    vecs[3] = '{32'h1234_56FF, 8'hFF, 1'b0};
    vecs[4] = '{32'h0000_0007, 8'h07, 1'b1};
    vecs[5] = '{32'h0000_0003, 8'h03, 1'b0};
    vecs[6] = '{32'h5555_5580, 8'h80, 1'b1};

    b2b[0] = '{32'hAAAA_AA11, 8'h11, 1'b0};
    b2b[1] = '{32'h0000_0022, 8'h22, 1'b0};
    b2b[2] = '{32'hFFFF_FF3C, 8'h3C, 1'b0};
    b2b[3] = '{32'h0102_0381, 8'h81, 1'b0};
    b2b[4] = '{32'h8000_007F, 8'h7F, 1'b1};
    b2b[5] = '{32'h0000_00E5, 8'hE5, 1'b1};

    ord[0] = '{32'h0000_0096, 8'h96, 1'b0};
    ord[1] = '{32'hFF00_0001, 8'h01, 1'b1};
    ord[2] = '{32'h0000_00C3, 8'hC3, 1'b0};
    ord[3] = '{32'h0000_005E, 8'h5E, 1'b1};

    rst     = 1'b0;
    in_stb  = 1'b0;
    in_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(in_ack), 32'd0);
    rst = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ack", 32'(in_ack), 32'd1);
    end

    // Single frames from the vector table
    for (int i = 0; i < 7; i++) begin
      push_word(vecs[i].word);
      chk("latency_tx", 32'(tx), 32'd1);
      chk("latency_busy", 32'(busy), 32'd0);
      check_frame(vecs[i].exp_byte, vecs[i].exp_par, "single");
      check_tail("single");
    end

    // Six words with in_stb held high: full throttling and back-to-back frames
    fork
      begin : drv
        int   n;
        int   e;
        int   t[6];
        int   exp_t[6];
        logic will;
        exp_t[0] = 0; exp_t[1] = 1; exp_t[2] = 2; exp_t[3] = 3; exp_t[4] = 4;
        exp_t[5] = FL * DIV + 2;
        n = 0;
        e = 0;
        in_data = b2b[0].word;
        in_stb  = 1'b1;
        while ((n < 6) && (e < 400)) begin
          will = in_ack;
          @(posedge clk);
          if (will) begin
            t[n] = e;
            n++;
          end
          e++;
          @(negedge clk);
          if (n < 6) in_data = b2b[n].word;
          else       in_stb  = 1'b0;
        end
        in_stb = 1'b0;
        chk("b2b_pushes", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++) chk("b2b_push_edge", 32'(t[i]), 32'(exp_t[i]));
        repeat (2 * FL * DIV - (FL * DIV + 2)) @(negedge clk);
        chk("b2b_ack_full", 32'(in_ack), 32'd0);
        @(negedge clk);
        chk("b2b_ack_after_pop", 32'(in_ack), 32'd1);
      end
      begin : mon
        @(negedge clk);
        for (int i = 0; i < 6; i++) check_frame(b2b[i].exp_byte, b2b[i].exp_par, "b2b");
      end
    join
    check_tail("b2b");

    // Reset mid-frame drops the frame and the queued word
    push_word(32'h0000_005A);
    push_word(32'h0000_0033);
    repeat (29) @(negedge clk);
    chk("pre_reset_tx", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ack", 32'(in_ack), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_tx", 32'(tx), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    push_word(32'h0000_0041);
    chk("post_rst_latency", 32'(tx), 32'd1);
    check_frame(8'h41, 1'b0, "post_rst");
    check_tail("post_rst");

    // Push coinciding with a STOP-end pop at count=2 keeps order
    fork
      begin : ord_drv
        push_word(ord[0].word);
        push_word(ord[1].word);
        push_word(ord[2].word);
        repeat (FL * DIV - 2) @(negedge clk);
        push_word(ord[3].word);
      end
      begin : ord_mon
        @(negedge clk);
        for (int i = 0; i < 4; i++) check_frame(ord[i].exp_byte, ord[i].exp_par, "order");
      end
    join
    check_tail("order");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
